// File: rtl/div_if.sv
// Handshake bundle between the EX stage and the divide sequencer.
// The master drives the EX-stage controls and operands; the slave returns stall and results.
interface div_if #(
  parameter int DATA_W = 32
);
  logic [7:0]        alucontrol;
  logic              en;
  logic              flush;
  logic [DATA_W-1:0] opdata1;
  logic [DATA_W-1:0] opdata2;
  logic              stall_div;
  logic              result_valid;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              div_zero;

  modport master (
    output alucontrol, en, flush, opdata1, opdata2,
    input  stall_div, result_valid, hi, lo, div_zero
  );

  modport slave (
    input  alucontrol, en, flush, opdata1, opdata2,
    output stall_div, result_valid, hi, lo, div_zero
  );
endinterface

// File: rtl/div_ctrl.sv
// Multi-cycle restoring divide sequencer for DIV/DIVU in the EX stage.
// Stalls the pipeline while iterating, then writes quotient to LO and remainder to HI.
module div_ctrl #(
  parameter int DATA_W = 32
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);
  localparam logic [7:0] DIV_CODE  = 8'b00011010;
  localparam logic [7:0] DIVU_CODE = 8'b00011011;
  localparam logic [5:0] LAST_ITER = 6'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic                start;
  logic                signed_op;
  logic                accept;
  logic [5:0]          cnt;
  logic                sop_q;
  logic                neg1_q;
  logic                neg2_q;
  logic                dz_q;
  logic [DATA_W-1:0]   dvd_q;
  logic [DATA_W-1:0]   dvs_q;
  logic [2*DATA_W:0]   work;
  logic [2*DATA_W:0]   shifted;
  logic signed [DATA_W:0] trial;
  logic [DATA_W-1:0]   quo_fix;
  logic [DATA_W-1:0]   rem_fix;

  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x,
                                                   input logic is_signed);
    if (is_signed && (x < 0))
      return DATA_W'(-x);
    return $unsigned(x);
  endfunction

  // Two's-complement negation wraps, so the most negative quotient stays itself.
  function automatic logic [DATA_W-1:0] apply_sign(input logic [DATA_W-1:0] mag,
                                                    input logic neg);
    return neg ? DATA_W'(-mag) : mag;
  endfunction

  assign start     = bus.en & ((bus.alucontrol == DIV_CODE) | (bus.alucontrol == DIVU_CODE));
  assign signed_op = (bus.alucontrol == DIV_CODE);
  assign accept    = (state == IDLE) & start & ~bus.flush;

  assign shifted = work << 1;
  assign trial   = $signed(shifted[2*DATA_W:DATA_W] - {1'b0, dvs_q});

  assign quo_fix = apply_sign(work[DATA_W-1:0], sop_q & (neg1_q ^ neg2_q));
  assign rem_fix = apply_sign(work[2*DATA_W-1:DATA_W], sop_q & neg1_q);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = (bus.opdata2 == '0) ? DONE : RUN;
      RUN:     if (cnt == LAST_ITER) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_comb begin
    bus.stall_div    = 1'b0;
    bus.result_valid = 1'b0;
    if (!bus.flush) begin
      unique case (state)
        IDLE:    bus.stall_div    = start;
        RUN:     bus.stall_div    = 1'b1;
        DONE:    bus.result_valid = 1'b1;
        default: ;
      endcase
    end
  end

  // Operand capture and iteration; these carry no reset since state gates their use.
  always_ff @(posedge clk) begin
    if (accept) begin
      sop_q  <= signed_op;
      neg1_q <= signed_op & bus.opdata1[DATA_W-1];
      neg2_q <= signed_op & bus.opdata2[DATA_W-1];
      dvd_q  <= bus.opdata1;
      dvs_q  <= magnitude(bus.opdata2, signed_op);
      work   <= {{(DATA_W+1){1'b0}}, magnitude(bus.opdata1, signed_op)};
    end else if ((state == RUN) && !bus.flush) begin
      if (trial < 0) work <= shifted;
      else           work <= {trial, shifted[DATA_W-1:1], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      dz_q         <= 1'b0;
      bus.hi       <= '0;
      bus.lo       <= '0;
      bus.div_zero <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      dz_q <= (bus.opdata2 == '0);
    end else if ((state == RUN) && !bus.flush) begin
      cnt <= cnt + 6'd1;
    end else if ((state == DONE) && !bus.flush) begin
      bus.lo       <= dz_q ? '1    : quo_fix;
      bus.hi       <= dz_q ? dvd_q : rem_fix;
      bus.div_zero <= dz_q;
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl with a cycle-level reference model and per-cycle compare.
module tb_div_ctrl;
  localparam logic [7:0] DIV  = 8'b00011010;
  localparam logic [7:0] DIVU = 8'b00011011;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   chk_on = 1'b0;

  div_if bus ();
  div_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h, want 0x%h", nm, act, exp);
    end
  endtask

  // Reference: architectural result of a divide, computed directly with integer arithmetic.
  function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    z = (b == 0);
    if (b == 0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 0;
    end else if (s) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b; r = a % b;
    end
  endfunction

  // Timing model: an accepted divide completes a fixed number of cycles after acceptance.
  int          cyc = 0;
  bit          busy = 0;
  int          acc_cyc = 0;
  int          done_cyc = 0;
  logic [31:0] p_lo, p_hi, e_lo = 0, e_hi = 0;
  logic        p_dz, e_dz = 0;

  function automatic bit is_start();
    return bus.en && (bus.alucontrol == DIV || bus.alucontrol == DIVU);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      busy = 0; e_lo = 0; e_hi = 0; e_dz = 0;
    end else if (bus.flush) begin
      busy = 0;
    end else if (!busy) begin
      if (is_start()) begin
        busy = 1;
        acc_cyc = cyc;
        done_cyc = cyc + ((bus.opdata2 == 0) ? 1 : 33);
        ref_div(bus.alucontrol == DIV, bus.opdata1, bus.opdata2, p_lo, p_hi, p_dz);
      end
    end else if (cyc == done_cyc) begin
      busy = 0; e_lo = p_lo; e_hi = p_hi; e_dz = p_dz;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_on && !rst) begin
      logic run, dn, e_stall, e_rv;
      run = busy && cyc > acc_cyc && cyc < done_cyc;
      dn  = busy && cyc == done_cyc;
      e_stall = !bus.flush && ((!busy && is_start()) || run);
      e_rv    = !bus.flush && dn;
      chk("cycle stall_div", 32'(bus.stall_div), 32'(e_stall));
      chk("cycle result_valid", 32'(bus.result_valid), 32'(e_rv));
      chk("cycle lo", bus.lo, e_lo);
      chk("cycle hi", bus.hi, e_hi);
      chk("cycle div_zero", 32'(bus.div_zero), 32'(e_dz));
    end
  end

  task automatic idle_inputs();
    bus.en = 1'b0;
    bus.opdata1 = $urandom;
    bus.opdata2 = $urandom;
  endtask

  task automatic step();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic start_div(input logic [7:0] code, input logic [31:0] a, input logic [31:0] b);
    bus.en = 1'b1; bus.alucontrol = code; bus.opdata1 = a; bus.opdata2 = b;
  endtask

  // Called in the start cycle; returns positioned in the cycle after result_valid.
  task automatic finish_div(input string nm, input int exp_lat);
    int lat, nst;
    lat = -1; nst = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.stall_div) nst++;
      if (bus.result_valid) begin
        lat = c;
        break;
      end
      step();
    end
    step();
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, " stall cycles"}, 32'(nst), 32'(exp_lat));
  endtask

  task automatic div_lit(input string nm, input logic [7:0] code, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input logic [31:0] q,
                         input logic [31:0] r, input logic z);
    start_div(code, a, b);
    finish_div(nm, lat);
    chk({nm, " lo"}, bus.lo, q);
    chk({nm, " hi"}, bus.hi, r);
    chk({nm, " div_zero"}, 32'(bus.div_zero), 32'(z));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush = 1'b0;
    bus.alucontrol = 8'h00;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset stall_div", 32'(bus.stall_div), 0);
    chk("reset result_valid", 32'(bus.result_valid), 0);
    chk("reset lo", bus.lo, 0);
    chk("reset hi", bus.hi, 0);
    chk("reset div_zero", 32'(bus.div_zero), 0);
    chk_on = 1'b1;
    step();

    div_lit("divu 100/7", DIVU, 100, 7, 33, 14, 2, 0);
    div_lit("div -7/2", DIV, 32'hFFFF_FFF9, 2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    div_lit("divu fff9/2", DIVU, 32'hFFFF_FFF9, 2, 33, 32'h7FFF_FFFC, 1, 0);
    div_lit("div overflow", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 0, 0);
    div_lit("div 100/-7", DIV, 100, 32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, 2, 0);
    div_lit("div 5/0", DIV, 5, 0, 1, 32'hFFFF_FFFF, 5, 1);
    div_lit("divu 6/4", DIVU, 6, 4, 33, 1, 2, 0);

    // Flush at cycle 10 of a run, then a fresh divide at cycle 11.
    start_div(DIVU, 1000, 3);
    repeat (10) step();
    bus.flush = 1'b1;
    @(negedge clk);
    chk("flush stall_div", 32'(bus.stall_div), 0);
    chk("flush result_valid", 32'(bus.result_valid), 0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush kept lo", bus.lo, 1);
    chk("flush kept hi", bus.hi, 2);
    div_lit("divu 9/3 after flush", DIVU, 9, 3, 33, 3, 0, 0);

    // Back-to-back: the second start lands in the cycle right after DONE.
    div_lit("b2b divu 10/3", DIVU, 10, 3, 33, 3, 1, 0);
    div_lit("b2b divu 20/6", DIVU, 20, 6, 33, 3, 2, 0);

    // Reset during a run.
    start_div(DIVU, 100, 7);
    repeat (15) step();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrun reset stall_div", 32'(bus.stall_div), 0);
    chk("midrun reset result_valid", 32'(bus.result_valid), 0);
    chk("midrun reset lo", bus.lo, 0);
    chk("midrun reset hi", bus.hi, 0);
    chk("midrun reset div_zero", 32'(bus.div_zero), 0);
    step();
    div_lit("divu 9/3 after reset", DIVU, 9, 3, 33, 3, 0, 0);

    repeat (3) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle divide sequencer for the EX stage. It recognises DIV/DIVU from the ALU control code and runs a 32-iteration restoring division. While the division runs, it stalls the pipeline, then delivers the quotient to LO and the remainder to HI. It sits beside the single-cycle ALU and feeds the HI/LO register write port.

## Interface
- `DIV_CODE`, 8'b00011010, alucontrol value for signed DIV
- `DIVU_CODE`, 8'b00011011, alucontrol value for unsigned DIVU
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `alucontrol`  in  8  EX-stage ALU control code
- `en`  in  1  EX instruction valid (not a bubble)
- `flush`  in  1  annul EX stage (exception/branch flush)
- `opdata1`  in  32  dividend (rs)
- `opdata2`  in  32  divisor (rt)
- `stall_div`  out  1  hold IF/ID/EX while high
- `result_valid`  out  1  one-cycle pulse; hi/lo hold a new result
- `hi`  out  32  remainder
- `lo`  out  32  quotient
- `div_zero`  out  1  last result came from a zero divisor

## Operation
- `start` = en & (alucontrol==DIV_CODE | alucontrol==DIVU_CODE); `signed_op` = (alucontrol==DIV_CODE).
- States: IDLE, RUN, DONE.
- **IDLE & start & !flush**
  - Latch `signed_op`, operand signs and operand magnitudes. Magnitude = |x| when signed, raw value otherwise.
  - Divisor==0: go to DONE directly.
  - Otherwise: clear the 6-bit counter and go to RUN.
- **RUN**
  - Working register is 65 bits, {rem[32:0], quo[31:0]}.
  - Each cycle: shift left 1 and trial-subtract the divisor from rem.
  - If the result is non-negative: keep the difference and set the quotient LSB.
  - When counter==31: go to DONE. Otherwise counter+1.
- **DONE**
  - Sign-fix: quotient is negated when signed and the operand signs differ. Remainder takes the dividend's sign when signed.
  - Register `lo`/`hi`, pulse `result_valid`, then return to IDLE.
- Zero divisor: lo=32'hFFFF_FFFF, hi=opdata1 (as latched), div_zero=1. Any non-zero divisor clears div_zero.
- Signed 0x8000_0000 / 0xFFFF_FFFF: wraps to lo=0x8000_0000, hi=0. No trap.
- `stall_div` = !flush & ((state==IDLE & start) | state==RUN). The output is combinational so the start cycle already stalls.
- `start` during DONE is ignored. The pipeline advances at the end of DONE, so a following divide is accepted in the next IDLE cycle.
- Operand changes after the start cycle have no effect.
- `flush` in any state: go to IDLE next cycle.
  - No result_valid pulse; hi/lo/div_zero unchanged.
  - A start coinciding with flush is not accepted.
- `rst` has priority over flush and start.

## Timing
- Reset values: state=IDLE, stall_div=0, result_valid=0, hi=0, lo=0, div_zero=0, counter=0.
- Non-zero divisor, start sampled in cycle 0:
  - RUN occupies cycles 1–32.
  - DONE is cycle 33: stall_div=0, result_valid=1, and hi/lo are valid on the outputs from cycle 34 onward (registered at end of 33).
  - stall_div is high in cycles 0–32, a 33-cycle stall.
- Zero divisor: stall_div high in cycle 0 only; DONE in cycle 1.
- result_valid is high for exactly one cycle per accepted divide.
- hi/lo hold their value until the next DONE.
- Reset mid-RUN: next cycle is IDLE with all outputs at reset values. The partial result is discarded.

## Test plan
- DIVU 100/7, start at cycle 0:
  - stall_div high for cycles 0–32.
  - result_valid at cycle 33.
  - Then lo=14, hi=2, div_zero=0.
- DIV 0xFFFF_FFF9 (−7) / 2: lo=0xFFFF_FFFD (−3), hi=0xFFFF_FFFF (−1). DIVU with the same operands: lo=0x7FFF_FFFC, hi=1.
- DIV 0x8000_0000 / 0xFFFF_FFFF: lo=0x8000_0000, hi=0. DIV 5/0: result_valid at cycle 1 with lo=0xFFFF_FFFF, hi=5, div_zero=1.
- DIVU started at cycle 0, flush at cycle 10:
  - stall_div=0 in cycle 10, state IDLE in cycle 11.
  - No result_valid; hi/lo keep their prior values.
  - A new DIVU 9/3 at cycle 11 gives lo=3, hi=0 at cycle 44.
- Back-to-back DIVU 10/3 then DIVU 20/6: first result_valid at 33 (lo=3, hi=1); second start accepted at 34; second result_valid at 67 (lo=3, hi=2).
- rst asserted at cycle 15 of a run: cycle 16 has all outputs at reset values and stall_div=0 with en low.
